// File: rtl/mem_wb_skid.sv
// mem_wb_skid: MEM->WB pipeline register with valid/ready handshake, flush, optional skid entry and x0 write suppression
// Ports: clk/rst (async, active-high); flush discards all held entries.
//   MEM side: mem_valid/mem_ready handshake carrying mem_wd, mem_wreg, mem_wdata.
//   WB side: wb_valid/wb_ready handshake carrying wb_wd, wb_wreg (gated by wb_valid), wb_wdata.
//   occ reports the number of held entries (0..2).
module mem_wb_skid #(
  parameter int REG_W = 32,
  parameter int ADDR_W = 5,
  parameter int SKID = 1,
  parameter int X0_SUPPRESS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [REG_W-1:0]  mem_wdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [REG_W-1:0]  wb_wdata,
  output logic [1:0]        occ
);
  localparam int PW = ADDR_W + 1 + REG_W;
  logic [PW-1:0] m_p, s_p, in_p;
  logic m_v, s_v, m_wr, accept, drain;
  assign in_p = {mem_wd, mem_wreg & ~((X0_SUPPRESS != 0) && (mem_wd == '0)), mem_wdata};
  // With the skid entry, ready depends only on registered state, cutting the wb_ready->mem_ready path
  assign mem_ready = (SKID != 0) ? !s_v : (!m_v || wb_ready);
  assign accept = mem_valid & mem_ready;
  assign drain = m_v & wb_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst || flush) begin
      m_p <= '0;
      s_p <= '0;
      m_v <= 1'b0;
      s_v <= 1'b0;
    end else if (!m_v || drain) begin
      // Skid entry is older than anything arriving now, so it always moves up first
      if (s_v) begin
        m_p <= s_p;
        s_v <= 1'b0;
      end else if (accept) begin
        m_p <= in_p;
        m_v <= 1'b1;
      end else
        m_v <= 1'b0;
    end else if (SKID != 0 && accept) begin
      s_p <= in_p;
      s_v <= 1'b1;
    end
  assign {wb_wd, m_wr, wb_wdata} = m_p;
  assign wb_valid = m_v;
  assign wb_wreg = m_wr & m_v;
  assign occ = {s_v, m_v ^ s_v};
endmodule
